// File: rtl/fp4_matmul_sequencer.sv
// Tile sequencer for the fp4 x fp4 -> i8 compute-slice array: gathers one operand
// byte per lane, strobes an accumulate per K step, then streams the accumulators out.
module fp4_matmul_sequencer #(
  parameter int COMPUTE_SLICES = 4,
  parameter int K_DEPTH        = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  input  logic [7:0]                                    in_data,
  output logic                                          in_ready,
  output logic [4*COMPUTE_SLICES-1:0]                   arr_a_data,
  output logic [4*COMPUTE_SLICES-1:0]                   arr_b_data,
  output logic                                          arr_clear,
  output logic                                          arr_acc_en,
  output logic [$clog2(COMPUTE_SLICES*COMPUTE_SLICES)-1:0] arr_out_sel,
  input  logic [7:0]                                    arr_result,
  output logic                                          out_valid,
  output logic [7:0]                                    out_data,
  input  logic                                          out_ready,
  output logic                                          busy,
  output logic                                          tile_done
);

  localparam int S      = COMPUTE_SLICES;
  localparam int LANE_W = $clog2(S);
  localparam int STEP_W = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int IDX_W  = $clog2(S * S);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(S - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(K_DEPTH - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(S * S - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [LANE_W-1:0] r_lane;
  logic [STEP_W-1:0] r_step;
  logic [IDX_W-1:0]  r_idx;
  logic [4*S-1:0]    r_a;
  logic [4*S-1:0]    r_b;
  logic              w_load_fire;
  logic              w_drain_fire;

  // Strobes are forced low while reset is high, whatever state is still registered.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    arr_clear    = 1'b0;
    arr_acc_en   = 1'b0;
    out_valid    = 1'b0;
    tile_done    = 1'b0;
    w_load_fire  = 1'b0;
    w_drain_fire = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_CLEAR: begin
          arr_clear    = 1'b1;
          w_state_next = ST_LOAD;
        end
        ST_LOAD: begin
          in_ready    = 1'b1;
          w_load_fire = in_valid;
          if (in_valid && (r_lane == LANE_LAST)) begin
            w_state_next = ST_MAC;
          end
        end
        ST_MAC: begin
          arr_acc_en   = 1'b1;
          w_state_next = (r_step == STEP_LAST) ? ST_DRAIN : ST_LOAD;
        end
        ST_DRAIN: begin
          out_valid    = 1'b1;
          w_drain_fire = out_ready;
          if (out_ready && (r_idx == IDX_LAST)) begin
            tile_done    = 1'b1;
            w_state_next = ST_CLEAR;
          end
        end
        default: w_state_next = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_lane  <= '0;
      r_step  <= '0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_CLEAR: begin
          r_lane <= '0;
          r_step <= '0;
          r_idx  <= '0;
        end
        ST_LOAD: begin
          if (w_load_fire) begin
            r_a[4*r_lane +: 4] <= in_data[3:0];
            r_b[4*r_lane +: 4] <= in_data[7:4];
            r_lane <= (r_lane == LANE_LAST) ? '0 : r_lane + LANE_W'(1);
          end
        end
        ST_MAC: begin
          r_step <= (r_step == STEP_LAST) ? '0 : r_step + STEP_W'(1);
        end
        ST_DRAIN: begin
          if (w_drain_fire) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign arr_a_data  = r_a;
  assign arr_b_data  = r_b;
  assign arr_out_sel = r_idx;
  assign out_data    = arr_result;
  assign busy        = (r_state != ST_CLEAR);

endmodule
